// File: rtl/panel_writer_if.sv
// panel_writer_if: write-port bundle from the front-panel sequencer to the
// register file and data memory. The sequencer drives it through the master
// modport. The register file and memory sample it through the slave modport.
interface panel_writer_if;
    logic        RegWE;
    logic [4:0]  WriteReg;
    logic [31:0] RegWData;
    logic        MemWE;
    logic [5:0]  WriteMem;
    logic [31:0] MemWData;

    modport master (
        output RegWE, WriteReg, RegWData,
        output MemWE, WriteMem, MemWData
    );

    modport slave (
        input RegWE, WriteReg, RegWData,
        input MemWE, WriteMem, MemWData
    );
endinterface

// File: rtl/panel_writer.sv
// panel_writer: front-panel write sequencer.
// Two push-buttons are synchronized and debounced. Each debounced press of
// BtnWrite issues one single-cycle write strobe to either the register file
// or the data memory. The strobe carries the captured switch values.
// Optional feature macro: PANEL_AUTO_INC_EN. When it is defined, an
// auto-incrementing address pointer is built. BtnLoad loads this pointer.

// Synchronizer and debouncer for one raw button. The level output changes only
// after DEBOUNCE_CYCLES consecutive synchronized samples that disagree with it.
module panel_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic level
);
    logic [1:0]  sync_q, sync_d;
    logic        level_q, level_d;
    logic [15:0] cnt_q, cnt_d;

    // Shift the synchronizer and count disagreeing samples. The counter is
    // cleared on a flip, so it never runs past DEBOUNCE_CYCLES.
    always_comb begin
        sync_d  = {sync_q[0], btn};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
endmodule

module panel_writer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  SelMem,
    input  logic [5:0]            Addr,
    input  logic [15:0]           DataIn,
    input  logic                  BtnWrite,
    input  logic                  BtnLoad,
    output logic                  Busy,
    output logic [5:0]            CurAddr,
    panel_writer_if.master        wr
);
    typedef enum logic [1:0] {IDLE, LATCH, WRITE, HOLD} state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [5:0]  cap_addr_q, cap_addr_d;
    logic [31:0] cap_data_q, cap_data_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [5:0]  write_mem_q, write_mem_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        wr_level;
    logic        wr_prev_q, wr_prev_d;
    logic        wr_evt;

    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_write (
        .clk   (clk),
        .clr   (clr),
        .btn   (BtnWrite),
        .level (wr_level)
    );

    assign wr_prev_d = wr_level;
    assign wr_evt    = wr_level & ~wr_prev_q;

`ifdef PANEL_AUTO_INC_EN
    logic        ld_level;
    logic        ld_prev_q, ld_prev_d;
    logic        ld_evt;
    logic [5:0]  ptr_q, ptr_d;

    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .clr   (clr),
        .btn   (BtnLoad),
        .level (ld_level)
    );

    assign ld_prev_d = ld_level;
    assign ld_evt    = ld_level & ~ld_prev_q;

    // Track the load button's previous level and hold the address pointer.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ld_prev_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            ld_prev_q <= ld_prev_d;
            ptr_q     <= ptr_d;
        end
    end

    assign CurAddr = ptr_q;
`else
    logic load_unused;
    assign load_unused = BtnLoad;
    assign CurAddr     = Addr;
`endif

    // Compute the next sequencer state, the captured operands and the write port outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        reg_we_d    = 1'b0;
        write_reg_d = write_reg_q;
        reg_wdata_d = reg_wdata_q;
        mem_we_d    = 1'b0;
        write_mem_d = write_mem_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PANEL_AUTO_INC_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PANEL_AUTO_INC_EN
                // A load event takes priority and discards a write event in the same cycle.
                if (ld_evt) begin
                    ptr_d = Addr;
                end else if (wr_evt) begin
                    state_d    = LATCH;
                    sel_d      = SelMem;
                    cap_addr_d = ptr_q;
                    cap_data_d = {16'h0000, DataIn};
                end
`else
                if (wr_evt) begin
                    state_d    = LATCH;
                    sel_d      = SelMem;
                    cap_addr_d = Addr;
                    cap_data_d = {16'h0000, DataIn};
                end
`endif
            end
            LATCH: begin
                // Enables are registered here, so they are high for the whole WRITE cycle.
                state_d = WRITE;
                if (sel_q) begin
                    mem_we_d    = 1'b1;
                    write_mem_d = cap_addr_q;
                    mem_wdata_d = cap_data_q;
                end else begin
                    reg_we_d    = (cap_addr_q[4:0] != 5'd0);
                    write_reg_d = cap_addr_q[4:0];
                    reg_wdata_d = cap_data_q;
                end
            end
            WRITE: begin
                state_d = HOLD;
`ifdef PANEL_AUTO_INC_EN
                if (sel_q) begin
                    ptr_d = ptr_q + 6'd1;
                end else begin
                    ptr_d = {1'b0, ptr_q[4:0] + 5'd1};
                end
`endif
            end
            HOLD: begin
                if (!wr_level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            reg_we_q    <= 1'b0;
            write_reg_q <= '0;
            reg_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            write_mem_q <= '0;
            mem_wdata_q <= '0;
            wr_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            reg_we_q    <= reg_we_d;
            write_reg_q <= write_reg_d;
            reg_wdata_q <= reg_wdata_d;
            mem_we_q    <= mem_we_d;
            write_mem_q <= write_mem_d;
            mem_wdata_q <= mem_wdata_d;
            wr_prev_q   <= wr_prev_d;
        end
    end

    assign Busy        = (state_q != IDLE);
    assign wr.RegWE    = reg_we_q;
    assign wr.WriteReg = write_reg_q;
    assign wr.RegWData = reg_wdata_q;
    assign wr.MemWE    = mem_we_q;
    assign wr.WriteMem = write_mem_q;
    assign wr.MemWData = mem_wdata_q;
endmodule

// File: tb/tb_panel_writer.sv
// tb_panel_writer: scoreboard bench for panel_writer with a short debounce.
// Expected writes are queued by the stimulus. A monitor checks every enable pulse.
module tb_panel_writer;
    logic        clk = 1'b0;
    logic        clr;
    logic        SelMem;
    logic [5:0]  Addr;
    logic [15:0] DataIn;
    logic        BtnWrite;
    logic        BtnLoad;
    logic        Busy;
    logic [5:0]  CurAddr;

    panel_writer_if wr_if ();

    panel_writer #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk      (clk),
        .clr      (clr),
        .SelMem   (SelMem),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .BtnWrite (BtnWrite),
        .BtnLoad  (BtnLoad),
        .Busy     (Busy),
        .CurAddr  (CurAddr),
        .wr       (wr_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_mem;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every enable pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (wr_if.RegWE || wr_if.MemWE) begin
            exp_t e;
            chk("single_we", {31'b0, wr_if.RegWE & wr_if.MemWE}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: RegWE=%b WriteReg=%0d MemWE=%b WriteMem=%0d, expected no write",
                         wr_if.RegWE, wr_if.WriteReg, wr_if.MemWE, wr_if.WriteMem);
            end else begin
                e = exp_q.pop_front();
                chk("we_target", {31'b0, wr_if.MemWE}, {31'b0, e.is_mem});
                if (e.is_mem) begin
                    chk("mem_addr", {26'b0, wr_if.WriteMem}, {26'b0, e.addr});
                    chk("mem_data", wr_if.MemWData, e.data);
                end else begin
                    chk("reg_addr", {27'b0, wr_if.WriteReg}, {27'b0, e.addr[4:0]});
                    chk("reg_data", wr_if.RegWData, e.data);
                end
            end
        end
    end

    // Press BtnWrite cleanly, release it, and check that Busy rises and falls within a bound.
    task automatic press_write(input string name, input int hold);
        bit busy_seen;
        int k;
        busy_seen = 1'b0;
        BtnWrite  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (Busy) busy_seen = 1'b1;
        end
        BtnWrite = 1'b0;
        k = 0;
        while (Busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_busy_seen"}, {31'b0, busy_seen}, 32'd1);
        chk({name, "_idle"}, {31'b0, Busy}, 32'd0);
        tick(10);
    endtask

    task automatic set_addr(input logic [5:0] a);
        Addr = a;
`ifdef PANEL_AUTO_INC_EN
        BtnLoad = 1'b1;
        tick(15);
        BtnLoad = 1'b0;
        tick(15);
`endif
    endtask

    initial begin
        int k;
        clr      = 1'b0;
        SelMem   = 1'b0;
        Addr     = 6'd0;
        DataIn   = 16'h0000;
        BtnWrite = 1'b0;
        BtnLoad  = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(1);

        // Reset state
        chk("rst_regwe",    {31'b0, wr_if.RegWE}, 32'd0);
        chk("rst_memwe",    {31'b0, wr_if.MemWE}, 32'd0);
        chk("rst_writereg", {27'b0, wr_if.WriteReg}, 32'd0);
        chk("rst_writemem", {26'b0, wr_if.WriteMem}, 32'd0);
        chk("rst_regwdata", wr_if.RegWData, 32'd0);
        chk("rst_memwdata", wr_if.MemWData, 32'd0);
        chk("rst_busy",     {31'b0, Busy}, 32'd0);
        chk("rst_curaddr",  {26'b0, CurAddr}, 32'd0);

        // Clean press to register 5
        SelMem = 1'b0;
        DataIn = 16'hBEEF;
        set_addr(6'd5);
        exp_q.push_back('{is_mem: 1'b0, addr: 6'd5, data: 32'h0000BEEF});
        press_write("reg5", 30);

        // Bouncy press to memory 63, then a long hold
        SelMem = 1'b1;
        DataIn = 16'h1234;
        set_addr(6'd63);
        exp_q.push_back('{is_mem: 1'b1, addr: 6'd63, data: 32'h00001234});
        for (int i = 0; i < 20; i++) begin
            BtnWrite = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        press_write("mem63", 100);

        // Register 0 is never written
        SelMem = 1'b0;
        DataIn = 16'h5555;
        set_addr(6'd0);
        press_write("reg0", 30);

        // Reset while in LATCH
        SelMem   = 1'b0;
        DataIn   = 16'h1111;
        set_addr(6'd7);
        BtnWrite = 1'b1;
        k = 0;
        while (!Busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("latch_busy", {31'b0, Busy}, 32'd1);
        clr      = 1'b0;
        BtnWrite = 1'b0;
        #1;
        chk("clr_regwe_async", {31'b0, wr_if.RegWE}, 32'd0);
        tick(3);
        clr = 1'b1;
        tick(1);
        chk("clr_regwe",    {31'b0, wr_if.RegWE}, 32'd0);
        chk("clr_memwe",    {31'b0, wr_if.MemWE}, 32'd0);
        chk("clr_writereg", {27'b0, wr_if.WriteReg}, 32'd0);
        chk("clr_writemem", {26'b0, wr_if.WriteMem}, 32'd0);
        chk("clr_regwdata", wr_if.RegWData, 32'd0);
        chk("clr_memwdata", wr_if.MemWData, 32'd0);
        chk("clr_busy",     {31'b0, Busy}, 32'd0);
`ifdef PANEL_AUTO_INC_EN
        chk("clr_curaddr",  {26'b0, CurAddr}, 32'd0);
`else
        chk("clr_curaddr",  {26'b0, CurAddr}, 32'd7);
`endif
        tick(30);

        // Register write, then a memory write; the register outputs must hold
        SelMem = 1'b0;
        DataIn = 16'hA5A5;
        set_addr(6'd9);
        exp_q.push_back('{is_mem: 1'b0, addr: 6'd9, data: 32'h0000A5A5});
        press_write("reg9", 30);
        SelMem = 1'b1;
        DataIn = 16'hFFFF;
        set_addr(6'd20);
        exp_q.push_back('{is_mem: 1'b1, addr: 6'd20, data: 32'h0000FFFF});
        press_write("mem20", 30);
        chk("hold_writereg", {27'b0, wr_if.WriteReg}, 32'd9);
        chk("hold_regwdata", wr_if.RegWData, 32'h0000A5A5);
        chk("hold_writemem", {26'b0, wr_if.WriteMem}, 32'd20);
        chk("hold_memwdata", wr_if.MemWData, 32'h0000FFFF);

`ifdef PANEL_AUTO_INC_EN
        // Pointer at 31: the writes go to 31, then 0 (dropped), then 1 and 2
        SelMem = 1'b0;
        set_addr(6'd31);
        chk("ptr_load31", {26'b0, CurAddr}, 32'd31);
        DataIn = 16'h0001;
        exp_q.push_back('{is_mem: 1'b0, addr: 6'd31, data: 32'h00000001});
        press_write("inc31", 30);
        chk("ptr_wrap", {26'b0, CurAddr}, 32'd0);
        DataIn = 16'h0002;
        press_write("inc0", 30);
        DataIn = 16'h0003;
        exp_q.push_back('{is_mem: 1'b0, addr: 6'd1, data: 32'h00000003});
        press_write("inc1", 30);
        DataIn = 16'h0004;
        exp_q.push_back('{is_mem: 1'b0, addr: 6'd2, data: 32'h00000004});
        press_write("inc2", 30);
        chk("ptr_after", {26'b0, CurAddr}, 32'd3);

        // Load and write pressed together: the load wins
        Addr     = 6'd10;
        DataIn   = 16'h00AA;
        BtnWrite = 1'b1;
        BtnLoad  = 1'b1;
        tick(30);
        BtnWrite = 1'b0;
        BtnLoad  = 1'b0;
        tick(20);
        chk("simul_curaddr", {26'b0, CurAddr}, 32'd10);
        chk("simul_busy", {31'b0, Busy}, 32'd0);
        Addr   = 6'd33;
        DataIn = 16'h00BB;
        exp_q.push_back('{is_mem: 1'b0, addr: 6'd10, data: 32'h000000BB});
        press_write("after_simul", 30);
`else
        // CurAddr follows the address switches
        Addr = 6'd42;
        #1;
        chk("curaddr_follow", {26'b0, CurAddr}, 32'd42);
`endif

        tick(20);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
